// File: rtl/rs_poly_normalizer.sv
// Monic normalizer for RS key-equation polynomials: buffers a coefficient stream,
// inverts the leading coefficient through a registered LUT and re-emits the scaled stream.
package rs_poly_normalizer_pkg;

   // GF(2^8) multiply, field polynomial x^8+x^4+x^3+x^2+1
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1D) : (x << 1);
      end
      return p;
   endfunction

   // a^254 == a^-1 for non-zero a; zero maps to zero
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] r;
      logic [7:0] p;
      r = 8'h01;
      p = a;
      for (int i = 1; i < 8; i++) begin
         p = gf_mul(p, p);
         r = gf_mul(r, p);
      end
      return r;
   endfunction

endpackage

module memory_inverse (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] addr,
   output logic [7:0] data
);
   import rs_poly_normalizer_pkg::*;

   always_ff @(posedge clk) begin
      if (!reset) data <= '0;
      else        data <= gf_inv(addr);
   end

endmodule

module rs_poly_normalizer #(
   parameter int unsigned NCOEF = 17
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_data,
   output logic       out_last,
   output logic [4:0] out_deg,
   output logic       zero_poly
);
   import rs_poly_normalizer_pkg::*;

   localparam int unsigned IW = (NCOEF > 1) ? $clog2(NCOEF) : 1;

   typedef enum logic [1:0] {LOAD, INV, INV_WAIT, SCALE} state_t;

   state_t        state;
   logic [7:0]    coef_mem [NCOEF];
   logic [IW-1:0] idx;
   logic [IW-1:0] k;
   logic [IW-1:0] k_next;
   logic [IW-1:0] lead_idx;
   logic [7:0]    lead;
   logic          lead_seen;
   logic          zero_poly_r;
   logic [7:0]    inv_r;
   logic [7:0]    inv_q;
   logic [7:0]    inv_sel;
   logic [4:0]    deg_calc;

   memory_inverse u_inv (
      .clk   (clk),
      .reset (reset),
      .addr  (lead),
      .data  (inv_q)
   );

   assign k_next   = k + 1'b1;
   assign inv_sel  = zero_poly_r ? 8'h01 : inv_q;
   assign deg_calc = 5'(NCOEF - 1) - 5'(lead_idx);

   // Coefficient buffer; contents are don't-care after reset
   always_ff @(posedge clk) begin
      if (state == LOAD && in_valid && in_ready) coef_mem[idx] <= in_data;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= LOAD;
         idx         <= '0;
         k           <= '0;
         lead_idx    <= '0;
         lead        <= '0;
         lead_seen   <= 1'b0;
         zero_poly_r <= 1'b0;
         inv_r       <= 8'h01;
         in_ready    <= 1'b0;
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_last    <= 1'b0;
         out_deg     <= '0;
         zero_poly   <= 1'b0;
      end else begin
         case (state)
            LOAD: begin
               in_ready <= 1'b1;
               if (in_valid && in_ready) begin
                  if (!lead_seen && in_data != 8'h00) begin
                     lead      <= in_data;
                     lead_idx  <= idx;
                     lead_seen <= 1'b1;
                  end
                  if (idx == IW'(NCOEF - 1)) begin
                     idx      <= '0;
                     in_ready <= 1'b0;
                     state    <= INV;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            INV: begin
               if (!lead_seen) begin
                  zero_poly_r <= 1'b1;
                  inv_r       <= 8'h01;
               end
               state <= INV_WAIT;
            end
            // First output beat is formed straight from the LUT result so SCALE starts valid
            INV_WAIT: begin
               inv_r     <= inv_sel;
               out_data  <= gf_mul(coef_mem[0], inv_sel);
               out_last  <= 1'b0;
               out_deg   <= zero_poly_r ? 5'd0 : deg_calc;
               zero_poly <= zero_poly_r;
               out_valid <= 1'b1;
               k         <= '0;
               state     <= SCALE;
            end
            SCALE: begin
               if (out_ready) begin
                  if (k == IW'(NCOEF - 1)) begin
                     out_valid   <= 1'b0;
                     out_last    <= 1'b0;
                     zero_poly   <= 1'b0;
                     zero_poly_r <= 1'b0;
                     lead_seen   <= 1'b0;
                     k           <= '0;
                     in_ready    <= 1'b1;
                     state       <= LOAD;
                  end else begin
                     k        <= k_next;
                     out_data <= gf_mul(coef_mem[k_next], inv_r);
                     out_last <= (k_next == IW'(NCOEF - 1));
                  end
               end
            end
            default: state <= LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_rs_poly_normalizer.sv
// Scoreboard bench for rs_poly_normalizer: NCOEF=4 and NCOEF=17 instances, directed vectors.
module tb_rs_poly_normalizer;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
      logic [4:0] deg;
      logic       zp;
   } beat_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid4, in_ready4, out_valid4, out_ready4, out_last4, zp4;
   logic [7:0] in_data4, out_data4;
   logic [4:0] out_deg4;
   logic       in_valid17, in_ready17, out_valid17, out_ready17, out_last17, zp17;
   logic [7:0] in_data17, out_data17;
   logic [4:0] out_deg17;

   beat_t q4[$];
   beat_t q17[$];
   beat_t e4, e17;
   int    checks = 0;
   int    passes = 0;

   always #5 clk = ~clk;

   rs_poly_normalizer #(.NCOEF(4)) u4 (
      .clk(clk), .reset(rst),
      .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
      .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
      .out_last(out_last4), .out_deg(out_deg4), .zero_poly(zp4)
   );

   rs_poly_normalizer #(.NCOEF(17)) u17 (
      .clk(clk), .reset(rst),
      .in_valid(in_valid17), .in_ready(in_ready17), .in_data(in_data17),
      .out_valid(out_valid17), .out_ready(out_ready17), .out_data(out_data17),
      .out_last(out_last17), .out_deg(out_deg17), .zero_poly(zp17)
   );

   function automatic void chk(input string name, input int act, input int exp_v);
      checks++;
      if (act == exp_v) passes++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
   endfunction

   // Monitors: a beat transfers at the next rising edge when valid&ready and reset is high
   always @(negedge clk) begin
      if (rst && out_valid4 && out_ready4) begin
         if (q4.size() == 0) begin
            checks++;
            $display("FAIL u4_extra_beat: got %0h, expected no beat", out_data4);
         end else begin
            e4 = q4.pop_front();
            chk("u4_data", out_data4, e4.data);
            chk("u4_last", out_last4, e4.last);
            chk("u4_deg", out_deg4, e4.deg);
            chk("u4_zero_poly", zp4, e4.zp);
         end
      end
   end

   always @(negedge clk) begin
      if (rst && out_valid17 && out_ready17) begin
         if (q17.size() == 0) begin
            checks++;
            $display("FAIL u17_extra_beat: got %0h, expected no beat", out_data17);
         end else begin
            e17 = q17.pop_front();
            chk("u17_data", out_data17, e17.data);
            chk("u17_last", out_last17, e17.last);
            chk("u17_deg", out_deg17, e17.deg);
            chk("u17_zero_poly", zp17, e17.zp);
         end
      end
   end

   task automatic exp4(input logic [31:0] w, input logic [4:0] deg, input logic zp);
      for (int i = 0; i < 4; i++) q4.push_back({w[31-8*i -: 8], (i == 3), deg, zp});
   endtask

   task automatic send4(input logic [31:0] w);
      logic acc;
      int   n;
      for (int i = 0; i < 4; i++) begin
         in_valid4 = 1'b1;
         in_data4  = w[31-8*i -: 8];
         acc = 1'b0;
         n   = 0;
         while (!acc && n < 50) begin
            @(posedge clk);
            acc = in_ready4;
            #1;
            n++;
         end
         if (!acc) chk("u4_input_timeout", 0, 1);
      end
      in_valid4 = 1'b0;
   endtask

   task automatic send17(input logic [7:0] c [17]);
      logic acc;
      int   n;
      for (int i = 0; i < 17; i++) begin
         in_valid17 = 1'b1;
         in_data17  = c[i];
         acc = 1'b0;
         n   = 0;
         while (!acc && n < 50) begin
            @(posedge clk);
            acc = in_ready17;
            #1;
            n++;
         end
         if (!acc) chk("u17_input_timeout", 0, 1);
      end
      in_valid17 = 1'b0;
   endtask

   task automatic drain4();
      int n = 0;
      while (q4.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk("u4_drain_left", q4.size(), 0);
   endtask

   task automatic drain17();
      int n = 0;
      while (q17.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk("u17_drain_left", q17.size(), 0);
   endtask

   task automatic wait_valid4();
      int n = 0;
      while (!out_valid4 && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("u4_valid_timeout", out_valid4, 1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] c17 [17];
      rst = 1'b0;
      in_valid4 = 1'b0;  in_data4 = '0;  out_ready4 = 1'b1;
      in_valid17 = 1'b0; in_data17 = '0; out_ready17 = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready4, 0);
      chk("rst_out_valid", out_valid4, 0);
      chk("rst_out_data", out_data4, 0);
      chk("rst_out_last", out_last4, 0);
      chk("rst_out_deg", out_deg4, 0);
      chk("rst_zero_poly", zp4, 0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_in_ready", in_ready4, 1);

      // 00,02,04,06 -> 00,01,02,03 deg 2, with latency check
      exp4(32'h00010203, 5'd2, 1'b0);
      send4(32'h00020406);
      chk("lat_edge0_valid", out_valid4, 0);
      @(posedge clk); #1;
      chk("lat_edge1_valid", out_valid4, 0);
      @(posedge clk); #1;
      chk("lat_edge2_valid", out_valid4, 1);
      drain4();

      // 03,06,05,00 -> inverse F4 -> 01,02,03,00 deg 3
      exp4(32'h01020300, 5'd3, 1'b0);
      send4(32'h03060500);
      drain4();

      // all-zero polynomial
      exp4(32'h00000000, 5'd0, 1'b1);
      send4(32'h00000000);
      drain4();
      chk("zero_back_in_ready", in_ready4, 1);
      chk("zero_back_out_valid", out_valid4, 0);

      // NCOEF=17, only degree-0 coefficient 8E
      for (int i = 0; i < 17; i++) c17[i] = 8'h00;
      c17[16] = 8'h8E;
      for (int i = 0; i < 16; i++) q17.push_back({8'h00, 1'b0, 5'd0, 1'b0});
      q17.push_back({8'h01, 1'b1, 5'd0, 1'b0});
      send17(c17);
      drain17();

      // backpressure at beat 2 with in_valid driven during SCALE
      exp4(32'h00010203, 5'd2, 1'b0);
      send4(32'h00020406);
      wait_valid4();
      @(posedge clk); #1;
      @(posedge clk); #1;
      out_ready4 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         in_valid4 = 1'b1;
         in_data4  = 8'hAA;
         @(posedge clk); #1;
         chk("bp_hold_data", out_data4, 8'h02);
         chk("bp_hold_valid", out_valid4, 1);
         chk("bp_hold_last", out_last4, 0);
         chk("bp_in_ready_low", in_ready4, 0);
      end
      in_valid4  = 1'b0;
      out_ready4 = 1'b1;
      drain4();

      // reset in the middle of SCALE after two beats
      exp4(32'h00010203, 5'd2, 1'b0);
      send4(32'h00020406);
      wait_valid4();
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("midrst_out_valid", out_valid4, 0);
      q4.delete();
      rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst_in_ready", in_ready4, 1);
      exp4(32'h00010203, 5'd2, 1'b0);
      send4(32'h00020406);
      drain4();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
